// File: rtl/sram_mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// State encoding, word-address shift and default timing/base parameters.
package sram_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int          WORD_SHIFT      = 2;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
    localparam int          DEF_WAIT_CYCLES = 5;

endpackage

// File: rtl/sram_wait_timer.sv
// 4-bit loadable access timer; o_tc flags the last strobe cycle.
// Counts up from 0 and holds once the terminal count WAIT_CYCLES-1 is reached.
import sram_mem_pkg::*;

module sram_wait_timer #(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    logic [3:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= 4'd0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_tc = (r_cnt == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller for a fixed-latency single-port SRAM; freezes the pipeline per access.
// Optional stall-cycle counter enabled by defining SRAM_STALL_CNT_EN.
//
// state  | meaning
// IDLE   | waiting for a request; Ready = ~req
// ACCESS | strobes asserted for WAIT_CYCLES cycles
// DONE   | one-cycle Ready pulse; read data valid
import sram_mem_pkg::*;

module sram_mem_ctrl #(
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          SRAM_AW     = 18
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        ADDR,
    input  logic [31:0]        WDATA,
    output logic               Ready,
    output logic [31:0]        RDATA,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [31:0]        SRAM_WDATA,
    input  logic [31:0]        SRAM_RDATA,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic [31:0]        STALL_CNT
);

    state_t             r_state;
    state_t             w_next;
    logic               w_req;
    logic               w_load;
    logic               w_en;
    logic               w_tc;
    logic [SRAM_AW-1:0] r_addr;
    logic [31:0]        r_wdata;
    logic               r_is_wr;
    logic [31:0]        r_rdata;

    assign w_req = MEM_R_EN | MEM_W_EN;

    sram_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_load  (w_load),
        .i_en    (w_en),
        .o_tc    (w_tc)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req) w_next = ACCESS;
            ACCESS:  if (w_tc)  w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Ready is forced high during reset so the pipeline is never frozen by a dead access.
    always_comb begin
        w_load    = (r_state == IDLE) && w_req;
        w_en      = (r_state == ACCESS);
        SRAM_WE_N = !((r_state == ACCESS) && r_is_wr);
        SRAM_OE_N = !((r_state == ACCESS) && !r_is_wr);
        Ready     = 1'b1;
        if (RST) begin
            case (r_state)
                IDLE:    Ready = !w_req;
                ACCESS:  Ready = 1'b0;
                DONE:    Ready = 1'b1;
                default: Ready = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_is_wr <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            if (w_load) begin
                r_addr  <= SRAM_AW'((ADDR - BASE_ADDR) >> WORD_SHIFT);
                r_wdata <= WDATA;
                r_is_wr <= MEM_W_EN;
            end
            if ((r_state == ACCESS) && w_tc && !r_is_wr) begin
                r_rdata <= SRAM_RDATA;
            end
        end
    end

    assign SRAM_ADDR  = r_addr;
    assign SRAM_WDATA = r_wdata;
    assign RDATA      = r_rdata;

`ifdef SRAM_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_stall_cnt <= 32'd0;
        end else if (!Ready) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign STALL_CNT = r_stall_cnt;
`else
    assign STALL_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed self-checking bench for sram_mem_ctrl at default parameters.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps

module tb_sram_mem_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        MEM_R_EN = 1'b0;
    logic        MEM_W_EN = 1'b0;
    logic [31:0] ADDR = 32'd0;
    logic [31:0] WDATA = 32'd0;
    logic        Ready;
    logic [31:0] RDATA;
    logic [17:0] SRAM_ADDR;
    logic [31:0] SRAM_WDATA;
    logic [31:0] SRAM_RDATA = 32'd0;
    logic        SRAM_WE_N;
    logic        SRAM_OE_N;
    logic [31:0] STALL_CNT;

    int n_cmp = 0;
    int n_bad = 0;

    // results of the most recent do_access
    int          a_ready_low, a_oe_low, a_we_low, a_both_low, a_first_idx;
    logic        a_first_ready, a_done, a_stable;
    logic [17:0] a_addr;
    logic [31:0] a_wdata, a_rdata;

    sram_mem_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .MEM_R_EN   (MEM_R_EN),
        .MEM_W_EN   (MEM_W_EN),
        .ADDR       (ADDR),
        .WDATA      (WDATA),
        .Ready      (Ready),
        .RDATA      (RDATA),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_WDATA (SRAM_WDATA),
        .SRAM_RDATA (SRAM_RDATA),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_OE_N  (SRAM_OE_N),
        .STALL_CNT  (STALL_CNT)
    );

    always #5 CLK = ~CLK;

    // Issues one request starting now; perturbs ADDR/WDATA once strobes appear.
    task automatic do_access(input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata);
        MEM_R_EN = rd;
        MEM_W_EN = wr;
        ADDR     = addr;
        WDATA    = wdata;
        a_ready_low = 0; a_oe_low = 0; a_we_low = 0; a_both_low = 0;
        a_first_idx = -1; a_first_ready = 1'bx; a_done = 1'b0; a_stable = 1'b1;
        a_addr = '0; a_wdata = '0; a_rdata = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (i == 0) a_first_ready = Ready;
            if (!Ready) a_ready_low++;
            if (!SRAM_OE_N) a_oe_low++;
            if (!SRAM_WE_N) a_we_low++;
            if (!SRAM_OE_N && !SRAM_WE_N) a_both_low++;
            if (!SRAM_OE_N || !SRAM_WE_N) begin
                if (a_first_idx < 0) begin
                    a_first_idx = i;
                    a_addr  = SRAM_ADDR;
                    a_wdata = SRAM_WDATA;
                    ADDR    = ~addr;
                    WDATA   = ~wdata;
                end else if (SRAM_ADDR !== a_addr || SRAM_WDATA !== a_wdata) begin
                    a_stable = 1'b0;
                end
            end
            if (Ready && i > 0) begin
                a_done  = 1'b1;
                a_rdata = RDATA;
                break;
            end
        end
        @(posedge CLK);
        #1;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (Ready !== 1'b1 || SRAM_WE_N !== 1'b1 || SRAM_OE_N !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ctrl: Ready/WE_N/OE_N got %b%b%b want 111", Ready, SRAM_WE_N, SRAM_OE_N);
        end
        n_cmp++;
        if (RDATA !== 32'd0 || SRAM_ADDR !== 18'd0 || SRAM_WDATA !== 32'd0 || STALL_CNT !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_data: RDATA=%h ADDR=%h WDATA=%h STALL=%0d want all 0",
                     RDATA, SRAM_ADDR, SRAM_WDATA, STALL_CNT);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_read();
        SRAM_RDATA = 32'hDEADBEEF;
        do_access(1'b1, 1'b0, 32'd1028, 32'hAAAA5555);
        n_cmp++;
        if (a_done !== 1'b1) begin n_bad++; $display("FAIL read_done: got %b want 1 (timeout)", a_done); end
        n_cmp++;
        if (a_ready_low != 6) begin n_bad++; $display("FAIL read_ready_low: got %0d want 6", a_ready_low); end
        n_cmp++;
        if (a_oe_low != 5) begin n_bad++; $display("FAIL read_oe_low: got %0d want 5", a_oe_low); end
        n_cmp++;
        if (a_we_low != 0) begin n_bad++; $display("FAIL read_we_low: got %0d want 0", a_we_low); end
        n_cmp++;
        if (a_addr !== 18'd1) begin n_bad++; $display("FAIL read_addr: got %h want 1", a_addr); end
        n_cmp++;
        if (a_first_idx != 1) begin n_bad++; $display("FAIL read_strobe_start: got %0d want 1", a_first_idx); end
        n_cmp++;
        if (a_stable !== 1'b1) begin n_bad++; $display("FAIL read_addr_stable: got %b want 1", a_stable); end
        n_cmp++;
        if (a_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_rdata: got %h want deadbeef", a_rdata); end
    endtask

    task automatic test_write();
        SRAM_RDATA = 32'h0BADF00D;
        do_access(1'b0, 1'b1, 32'd1024, 32'h12345678);
        n_cmp++;
        if (a_ready_low != 6) begin n_bad++; $display("FAIL write_ready_low: got %0d want 6", a_ready_low); end
        n_cmp++;
        if (a_we_low != 5) begin n_bad++; $display("FAIL write_we_low: got %0d want 5", a_we_low); end
        n_cmp++;
        if (a_oe_low != 0) begin n_bad++; $display("FAIL write_oe_low: got %0d want 0", a_oe_low); end
        n_cmp++;
        if (a_addr !== 18'd0) begin n_bad++; $display("FAIL write_addr: got %h want 0", a_addr); end
        n_cmp++;
        if (a_wdata !== 32'h12345678) begin n_bad++; $display("FAIL write_wdata: got %h want 12345678", a_wdata); end
        n_cmp++;
        if (a_stable !== 1'b1) begin n_bad++; $display("FAIL write_stable: got %b want 1", a_stable); end
        n_cmp++;
        if (a_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL write_rdata_hold: got %h want deadbeef", a_rdata); end
    endtask

    // Both enables: write wins. ADDR=1020 is below base: (-4)>>2 truncated to 18 bits = 3FFFF.
    task automatic test_both_wrap();
        do_access(1'b1, 1'b1, 32'd1020, 32'hCAFEF00D);
        n_cmp++;
        if (a_we_low != 5 || a_oe_low != 0) begin
            n_bad++; $display("FAIL both_strobes: we_low=%0d oe_low=%0d want 5/0", a_we_low, a_oe_low);
        end
        n_cmp++;
        if (a_addr !== 18'h3FFFF) begin n_bad++; $display("FAIL wrap_addr: got %h want 3ffff", a_addr); end
        n_cmp++;
        if (a_both_low != 0) begin n_bad++; $display("FAIL strobe_overlap: got %0d want 0", a_both_low); end
        n_cmp++;
        if (a_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL both_rdata_hold: got %h want deadbeef", a_rdata); end
    endtask

    task automatic test_back_to_back();
        SRAM_RDATA = 32'h00C0FFEE;
        do_access(1'b1, 1'b0, 32'd1040, 32'd0);
        n_cmp++;
        if (a_ready_low != 6 || a_rdata !== 32'h00C0FFEE) begin
            n_bad++; $display("FAIL b2b_read: ready_low=%0d rdata=%h want 6/00c0ffee", a_ready_low, a_rdata);
        end
        do_access(1'b0, 1'b1, 32'd1048, 32'h87654321);
        n_cmp++;
        if (a_first_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_gap: first Ready got %b want 0", a_first_ready); end
        n_cmp++;
        if (a_first_idx != 1 || a_we_low != 5) begin
            n_bad++; $display("FAIL b2b_write_start: idx=%0d we_low=%0d want 1/5", a_first_idx, a_we_low);
        end
        n_cmp++;
        if (a_addr !== 18'd6 || a_wdata !== 32'h87654321) begin
            n_bad++; $display("FAIL b2b_write_data: addr=%h wdata=%h want 6/87654321", a_addr, a_wdata);
        end
    endtask

    task automatic test_reset_mid_access();
        int strobes;
        logic seen;
        strobes = 0;
        seen = 1'b0;
        MEM_R_EN = 1'b1;
        ADDR     = 32'd1100;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (!SRAM_OE_N) strobes++;
            if (strobes == 3) begin seen = 1'b1; break; end
        end
        n_cmp++;
        if (seen !== 1'b1) begin n_bad++; $display("FAIL rst_mid_reach: got %b want 1 (timeout)", seen); end
        RST = 1'b0;
        #1;
        n_cmp++;
        if (Ready !== 1'b1 || SRAM_OE_N !== 1'b1 || SRAM_WE_N !== 1'b1) begin
            n_bad++; $display("FAIL rst_mid_outputs: Ready/WE_N/OE_N got %b%b%b want 111", Ready, SRAM_WE_N, SRAM_OE_N);
        end
        n_cmp++;
        if (RDATA !== 32'd0 || SRAM_ADDR !== 18'd0) begin
            n_bad++; $display("FAIL rst_mid_regs: RDATA=%h ADDR=%h want 0/0", RDATA, SRAM_ADDR);
        end
        MEM_R_EN = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        strobes = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (!SRAM_OE_N || !SRAM_WE_N || !Ready) strobes++;
        end
        n_cmp++;
        if (strobes != 0) begin n_bad++; $display("FAIL rst_abandon: busy cycles got %0d want 0", strobes); end
        @(posedge CLK);
        #1;
        SRAM_RDATA = 32'h5A5A1234;
        do_access(1'b1, 1'b0, 32'd1028, 32'd0);
        n_cmp++;
        if (a_ready_low != 6 || a_rdata !== 32'h5A5A1234) begin
            n_bad++; $display("FAIL rst_recover: ready_low=%0d rdata=%h want 6/5a5a1234", a_ready_low, a_rdata);
        end
    endtask

    task automatic test_stall_cnt();
        logic [31:0] exp_cnt;
`ifdef SRAM_STALL_CNT_EN
        exp_cnt = 32'd12;
`else
        exp_cnt = 32'd0;
`endif
        RST = 1'b0;
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        do_access(1'b1, 1'b0, 32'd1028, 32'd0);
        do_access(1'b1, 1'b0, 32'd1032, 32'd0);
        @(negedge CLK);
        n_cmp++;
        if (STALL_CNT !== exp_cnt) begin n_bad++; $display("FAIL stall_cnt: got %0d want %0d", STALL_CNT, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_both_wrap();
        test_back_to_back();
        test_reset_mid_access();
        test_stall_cnt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
